// File: rtl/i_mem_loader_if.sv
// Byte-stream handshake into the instruction loader.
// Source drives byte_in/byte_valid; loader answers with byte_ready.
interface i_mem_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/i_mem_loader.sv
// Instruction memory loader: packs a big-endian byte stream into
// 32-bit words and serves them on a combinational fetch port.
module i_mem_loader #(
    parameter int TAMANHO_MEMORIA = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [6:0]          word_count,
    i_mem_loader_if.slave       bus,
    input  logic [31:0]         address,
    output logic [31:0]         i_out,
    output logic                busy,
    output logic                done,
    output logic [6:0]          words_loaded,
    output logic                error
);

    localparam int AW =
        (TAMANHO_MEMORIA > 1) ? $clog2(TAMANHO_MEMORIA) : 1;
    localparam logic [6:0] DEPTH = 7'(TAMANHO_MEMORIA);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [23:0] partial;
    logic [6:0]  target;
    logic        too_many;
    logic        take;
    logic        last_byte;
    logic        wr_en;
    logic [31:0] word;
    logic        unused;

    // Storage starts zeroed and survives both reset and start.
    logic [31:0] mem [TAMANHO_MEMORIA] = '{default: '0};

    assign too_many  = word_count > DEPTH;
    assign take      = (state == LOAD) && bus.byte_valid
                       && bus.byte_ready;
    assign last_byte = take && (byte_idx == 2'd3);
    assign wr_en     = last_byte && !reset;
    assign word      = {partial, bus.byte_in};
    assign unused    = ^address[1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            bus.byte_ready <= 1'b0;
            words_loaded   <= '0;
            byte_idx       <= '0;
            partial        <= '0;
            target         <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        byte_idx     <= '0;
                        partial      <= '0;
                        words_loaded <= '0;
                        error        <= too_many;
                        target       <= too_many ? DEPTH : word_count;
                        if (word_count == 7'd0) begin
                            state          <= DONE;
                            done           <= 1'b1;
                            busy           <= 1'b0;
                            bus.byte_ready <= 1'b0;
                        end else begin
                            state          <= LOAD;
                            done           <= 1'b0;
                            busy           <= 1'b1;
                            bus.byte_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (take) begin
                        byte_idx <= byte_idx + 2'd1;
                        partial  <= word[23:0];
                        if (last_byte) begin
                            words_loaded <= words_loaded + 7'd1;
                            if (words_loaded + 7'd1 == target) begin
                                state          <= DONE;
                                busy           <= 1'b0;
                                done           <= 1'b1;
                                bus.byte_ready <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // words_loaded doubles as the write pointer.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[words_loaded[AW-1:0]] <= word;
        end
    end

    always_comb begin
        i_out = '0;
        if (address[31:2] < 30'(TAMANHO_MEMORIA)) begin
            i_out = mem[address[AW+1:2]];
        end
    end

endmodule

// File: tb/tb_i_mem_loader.sv
// Scoreboard bench for i_mem_loader: expected words are queued as
// their 4th byte is driven and checked once the loader commits them.
module tb_i_mem_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        start;
    logic [6:0]  word_count;
    logic [31:0] address;
    logic [31:0] i_out;
    logic        busy;
    logic        done;
    logic [6:0]  words_loaded;
    logic        error;

    int          checks;
    int          errors;
    int          exp_wl;
    exp_t        sb[$];
    logic [7:0]  stream[$];

    i_mem_loader_if bus ();

    i_mem_loader #(.TAMANHO_MEMORIA(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .word_count   (word_count),
        .bus          (bus),
        .address      (address),
        .i_out        (i_out),
        .busy         (busy),
        .done         (done),
        .words_loaded (words_loaded),
        .error        (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic start_load(input logic [6:0] n);
        start      = 1'b1;
        word_count = n;
        exp_wl     = 0;
        cycle();
        start      = 1'b0;
    endtask

    task automatic feed(input bit throttle);
        exp_t e;
        for (int i = 0; i < stream.size(); i++) begin
            if (throttle) begin
                bus.byte_in    = 8'hFF;
                bus.byte_valid = 1'b0;
                cycle();
                checks++;
                if (words_loaded !== 7'(exp_wl)) begin
                    $display("FAIL bubble_wl got %0d want %0d",
                             words_loaded, exp_wl);
                    errors++;
                end
            end
            bus.byte_in    = stream[i];
            bus.byte_valid = 1'b1;
            if (i % 4 == 3 && exp_wl < 64) begin
                e.addr = 32'(exp_wl * 4);
                e.data = {stream[i-3], stream[i-2],
                          stream[i-1], stream[i]};
                sb.push_back(e);
                exp_wl++;
            end
            cycle();
            bus.byte_valid = 1'b0;
            checks++;
            if (words_loaded !== 7'(exp_wl)) begin
                $display("FAIL words_loaded got %0d want %0d",
                         words_loaded, exp_wl);
                errors++;
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                address = e.addr;
                #1;
                checks++;
                if (i_out !== e.data) begin
                    $display("FAIL word@%0h got %h want %h",
                             e.addr, i_out, e.data);
                    errors++;
                end
            end
        end
        stream.delete();
    endtask

    task automatic chk_flags(input string tag, input logic b,
                             input logic d, input logic r,
                             input logic er);
        checks++;
        if ({busy, done, bus.byte_ready, error} !== {b, d, r, er}) begin
            $display("FAIL %s busy/done/rdy/err got %b%b%b%b want %b%b%b%b",
                     tag, busy, done, bus.byte_ready, error,
                     b, d, r, er);
            errors++;
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] a,
                            input logic [31:0] w);
        address = a;
        #1;
        checks++;
        if (i_out !== w) begin
            $display("FAIL %s i_out got %h want %h", tag, i_out, w);
            errors++;
        end
    endtask

    task automatic chk_wl(input string tag, input int n);
        checks++;
        if (words_loaded !== 7'(n)) begin
            $display("FAIL %s words_loaded got %0d want %0d",
                     tag, words_loaded, n);
            errors++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_wl("reset", 0);
        chk_word("reset_mem0", 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid_word();
        start_load(7'd2);
        stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        feed(1'b0);
        // reset wins over a simultaneous start and byte
        reset          = 1'b1;
        start          = 1'b1;
        word_count     = 7'd3;
        bus.byte_in    = 8'h77;
        bus.byte_valid = 1'b1;
        cycle();
        reset          = 1'b0;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        chk_flags("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_wl("mid_reset", 0);
        chk_word("mid_keep0", 32'h0, 32'h11223344);
        chk_word("mid_drop1", 32'h4, 32'h0);
        start_load(7'd1);
        stream = '{8'h01, 8'h02, 8'h03, 8'h04};
        feed(1'b0);
        chk_flags("mid_reload", 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_load_two(input bit throttle);
        start_load(7'd2);
        chk_flags("two_start", 1'b1, 1'b0, 1'b1, 1'b0);
        stream = '{8'h8C, 8'h01, 8'h00, 8'h04,
                   8'hAC, 8'h02, 8'h00, 8'h08};
        feed(throttle);
        chk_flags("two_done", 1'b0, 1'b1, 1'b0, 1'b0);
        chk_wl("two_done", 2);
        chk_word("two_w0", 32'h0, 32'h8C010004);
        chk_word("two_w1", 32'h4, 32'hAC020008);
    endtask

    task automatic test_boundary();
        start_load(7'd0);
        chk_flags("zero", 1'b0, 1'b1, 1'b0, 1'b0);
        chk_wl("zero", 0);
        chk_word("zero_keep", 32'h0, 32'h8C010004);
        chk_word("addr256", 32'd256, 32'h0);
        chk_word("addr_max", 32'hFFFF_FFFC, 32'h0);
        chk_word("addr_unal", 32'h7, 32'hAC020008);
        start_load(7'd2);
        stream = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        feed(1'b0);
        start      = 1'b1;
        word_count = 7'd5;
        cycle();
        start      = 1'b0;
        chk_flags("ign_start", 1'b1, 1'b0, 1'b1, 1'b0);
        chk_wl("ign_start", 1);
        stream = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        feed(1'b0);
        chk_flags("ign_done", 1'b0, 1'b1, 1'b0, 1'b0);
        chk_wl("ign_done", 2);
    endtask

    task automatic test_overflow();
        start_load(7'd100);
        chk_flags("ovf_start", 1'b1, 1'b0, 1'b1, 1'b1);
        for (int j = 0; j < 256; j++) stream.push_back(8'(j * 7 + 3));
        feed(1'b0);
        chk_flags("ovf_done", 1'b0, 1'b1, 1'b0, 1'b1);
        chk_wl("ovf_done", 64);
        bus.byte_in    = 8'h99;
        bus.byte_valid = 1'b1;
        cycle();
        bus.byte_valid = 1'b0;
        chk_wl("ovf_extra", 64);
        chk_word("ovf_w63", 32'd252,
                 {8'(252 * 7 + 3), 8'(253 * 7 + 3),
                  8'(254 * 7 + 3), 8'(255 * 7 + 3)});
        chk_word("ovf_256", 32'd256, 32'h0);
        start_load(7'd1);
        chk_flags("ovf_clear", 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        exp_wl         = 0;
        reset          = 1'b0;
        start          = 1'b0;
        word_count     = '0;
        address        = '0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        test_reset();
        test_reset_mid_word();
        test_load_two(1'b0);
        test_load_two(1'b1);
        test_boundary();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
